axi_slave_mem: RTL and testbench

- Synthesizable AXI3-style slave memory; the endpoint that consumes the master-side traffic on the team's AXI bus interface (`clk`, 4-bit IDs/len, `wid`, 32-bit addr/data).
- Serves one write burst and one read burst concurrently, one outstanding transaction per direction.
- Supports FIXED, INCR and WRAP bursts with byte strobes.
- Used as the DUT-side slave under the AXI VIP master agent.

---
 rtl/axi_slave_mem.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI3-style slave memory: one write burst and one read burst in flight, FIXED/INCR/WRAP with byte strobes.
// Latency: AW->first W accept 1 cycle, last W->B 1 cycle, AR->first R 1 cycle, zero-bubble R beats.
// Backpressure: B and R outputs hold stable while bready/rready low; a new AW/AR is accepted only after its burst retires.
module axi_slave_mem #(
    parameter int DEPTH     = 1024,
    parameter bit OKAY_ONLY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = OKAY_ONLY ? 2'b00 : 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] bytes;
        logic [31:0] total;
        bytes = 32'd1 << size;
        total = ({28'd0, len} + 32'd1) * bytes;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~(total - 32'd1)) | ((addr + bytes) & (total - 32'd1));
            default: next_addr = (addr & ~(bytes - 32'd1)) + bytes;
        endcase
    endfunction

    function automatic logic req_err(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        req_err = (size > 3'd2) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    function automatic logic oor(input logic [31:0] addr);
        oor = (addr[31:AW+2] != '0);
    endfunction

    // ---------------- write side ----------------
    wstate_t     wstate, wstate_d;
    logic        awready_d, wready_d, bvalid_d;
    logic [3:0]  w_id, w_len, w_cnt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [31:0] w_addr;
    logic        w_err, w_beat, w_beat_err;

    assign w_beat     = wvalid && wready;
    assign w_beat_err = oor(w_addr) || (wid != w_id) || (wlast != (w_cnt == w_len));

    always_comb begin
        wstate_d  = wstate;
        awready_d = awready;
        wready_d  = wready;
        bvalid_d  = bvalid;
        case (wstate)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: if (w_beat && (w_cnt == w_len)) begin
                wready_d = 1'b0;
                bvalid_d = 1'b1;
                wstate_d = W_RESP;
            end
            W_RESP: if (bvalid && bready) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                wstate_d  = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_addr  <= '0;
            w_err   <= 1'b0;
        end else begin
            wstate  <= wstate_d;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            if (wstate == W_IDLE && awvalid && awready) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_err   <= req_err(awlen, awsize, awburst);
            end
            if (w_beat) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 4'd1;
                w_err  <= w_err | w_beat_err;
                if (w_cnt == w_len) begin
                    bid   <= w_id;
                    bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Storage is deliberately outside the reset domain; out-of-range beats never touch it.
    always_ff @(posedge clk) begin
        if (w_beat && !oor(w_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    rstate_t     rstate, rstate_d;
    logic        arready_d, rvalid_d;
    logic [3:0]  r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [31:0] r_addr, r_next;
    logic        r_err, r_beat;

    assign r_beat = rvalid && rready;
    assign r_next = next_addr(r_addr, r_len, r_size, r_burst);

    always_comb begin
        rstate_d  = rstate;
        arready_d = arready;
        rvalid_d  = rvalid;
        case (rstate)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: if (r_beat && rlast) begin
                rvalid_d  = 1'b0;
                arready_d = 1'b1;
                rstate_d  = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Reads sample mem with the same edge as a write, so a colliding read sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            rstate  <= rstate_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            if (rstate == R_IDLE && arvalid && arready) begin
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_cnt   <= '0;
                r_err   <= req_err(arlen, arsize, arburst);
                rid     <= arid;
                rlast   <= (arlen == 4'd0);
                rdata   <= oor(araddr) ? 32'd0 : mem[araddr[AW+1:2]];
                rresp   <= (req_err(arlen, arsize, arburst) || oor(araddr)) ? RESP_SLVERR : RESP_OKAY;
            end else if (r_beat) begin
                if (rlast) begin
                    rlast <= 1'b0;
                end else begin
                    r_addr <= r_next;
                    r_cnt  <= r_cnt + 4'd1;
                    rlast  <= ((r_cnt + 4'd1) == r_len);
                    rdata  <= oor(r_next) ? 32'd0 : mem[r_next[AW+1:2]];
                    rresp  <= (r_err || oor(r_next)) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: a burst-level memory model predicts every R and B beat.
module tb_axi_slave_mem;
    localparam int DEPTH = 256;
    localparam logic [31:0] MEMTOP = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid = '0, awlen = '0, wid = '0, arid = '0, arlen = '0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axi_slave_mem #(.DEPTH(DEPTH), .OKAY_ONLY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int nvec = 0;
    int nerr = 0;

    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; logic chk; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    rexp_t exp_r[$];
    bexp_t exp_b[$];
    logic [31:0] shadow [DEPTH];
    logic [31:0] rd_beats [16];
    logic [1:0]  rd_resp [16];
    logic [1:0]  last_bresp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: DUT did not respond within the cycle budget", name);
    endtask

    function automatic logic stat_err(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    // Beat i address from first principles: wrap within the aligned window, or step from the aligned start.
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
        longint unsigned a, bytes, total, base;
        a = addr;
        bytes = 64'd1 << size;
        total = (64'(len) + 64'd1) * bytes;
        case (burst)
            2'b00: return addr;
            2'b10: begin
                base = a - (a % total);
                return 32'(base + ((a - base) + longint'(i) * bytes) % total);
            end
            default: return (i == 0) ? addr : 32'((a / bytes) * bytes + longint'(i) * bytes);
        endcase
    endfunction

    task automatic expect_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic serr, o;
        serr = stat_err(len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, size, burst, i);
            o = (a >= MEMTOP);
            exp_r.push_back('{id, o ? 32'd0 : shadow[a >> 2], (serr || o) ? 2'b10 : 2'b00,
                              (i == int'(len)), !serr || burst == 2'b11});
        end
    endtask

    // Single compare process: every R/B handshake against the model, and hold stability under backpressure.
    logic        r_hold = 0, b_hold = 0, h_rlast;
    logic [31:0] h_rdata;
    logic [3:0]  h_rid, h_bid;
    logic [1:0]  h_rresp, h_bresp;
    always @(negedge clk) begin : monitor
        rexp_t re;
        bexp_t be;
        if (!rst_n) begin
            r_hold = 0;
            b_hold = 0;
        end else begin
            if (r_hold) begin
                chk("r_hold_valid", rvalid, 1'b1);
                chk("r_hold_data", rdata, h_rdata);
                chk("r_hold_id", rid, h_rid);
                chk("r_hold_resp_last", {rresp, rlast}, {h_rresp, h_rlast});
            end
            if (b_hold) begin
                chk("b_hold_valid", bvalid, 1'b1);
                chk("b_hold_id_resp", {bid, bresp}, {h_bid, h_bresp});
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL r_unexpected: beat rdata=0x%08h arrived, none expected", rdata);
                end else begin
                    re = exp_r.pop_front();
                    chk("r_id", rid, re.id);
                    chk("r_resp", rresp, re.resp);
                    chk("r_last", rlast, re.last);
                    if (re.chk) chk("r_data", rdata, re.data);
                end
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL b_unexpected: response bid=%0d arrived, none expected", bid);
                end else begin
                    be = exp_b.pop_front();
                    chk("b_id", bid, be.id);
                    chk("b_resp", bresp, be.resp);
                end
            end
            r_hold = rvalid && !rready;
            b_hold = bvalid && !bready;
            h_rdata = rdata; h_rid = rid; h_rresp = rresp; h_rlast = rlast;
            h_bid = bid; h_bresp = bresp;
        end
    end

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                             input logic [3:0] strb, input int bad_wid_beat, input int early_last_beat,
                             input int b_hold_cycles);
        logic err;
        logic [31:0] a;
        int held;
        bit done;
        err = stat_err(len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            if (beat_addr(addr, len, size, burst, i) >= MEMTOP) err = 1;
            if (i == bad_wid_beat || (i == early_last_beat && i != int'(len))) err = 1;
        end
        exp_b.push_back('{id, err ? 2'b10 : 2'b00});
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (awready) done = 1;
        end
        if (!done) timeout("aw_accept");
        @(posedge clk); #1;
        awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1;
            wid = (i == bad_wid_beat) ? ~id : id;
            wdata = d0 + 32'(i);
            wstrb = strb;
            wlast = (i == int'(len)) || (i == early_last_beat);
            done = 0;
            for (int t = 0; t < 50 && !done; t++) begin
                @(negedge clk);
                if (wready) done = 1;
            end
            if (!done) timeout("w_accept");
            a = beat_addr(addr, len, size, burst, i);
            if (a < MEMTOP)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) shadow[a >> 2][8*b +: 8] = wdata[8*b +: 8];
            @(posedge clk); #1;
        end
        wvalid = 0; wlast = 0;
        held = 0;
        bready = (b_hold_cycles == 0);
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (bvalid && bready) begin
                done = 1;
                last_bresp = bresp;
            end else if (bvalid) begin
                held++;
                chk("aw_blocked_in_resp", awready, 1'b0);
            end
            @(posedge clk); #1;
            bready = (held >= b_hold_cycles) && !done;
        end
        if (!done) timeout("b_handshake");
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int hold_beat, input int hold_cycles);
        int beat, held;
        bit done;
        expect_read(id, addr, len, size, burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (arready) done = 1;
        end
        if (!done) timeout("ar_accept");
        @(posedge clk); #1;
        arvalid = 0;
        beat = 0; held = 0; done = 0;
        rready = !(hold_beat == 0 && hold_cycles > 0);
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (rvalid && rready) begin
                if (beat < 16) begin
                    rd_beats[beat] = rdata;
                    rd_resp[beat] = rresp;
                end
                if (rlast) done = 1;
                beat++;
            end else if (rvalid) begin
                held++;
            end
            @(posedge clk); #1;
            rready = !done && !(beat == hold_beat && held < hold_cycles);
        end
        if (!done) timeout("r_last");
        chk("r_beat_count", beat, int'(len) + 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int beats;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {awready, wready, bvalid, arready, rvalid, rlast}, 6'd0);
        chk("reset_ids_resp", {bid, rid, bresp, rresp}, 12'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("ready_before_edge", {awready, arready}, 2'b00);
        @(posedge clk); #1;
        chk("ready_after_edge", {awready, arready}, 2'b11);

        // Preload words 0x00..0x3C with 0x100+k.
        axi_write(4'd1, 32'h0, 4'd15, 3'd2, 2'b01, 32'h100, 4'hF, -1, -1, 0);

        axi_write(4'd2, 32'h10, 4'd3, 3'd2, 2'b01, 32'hA0, 4'hF, -1, -1, 0);
        chk("incr_bresp", last_bresp, 2'b00);
        axi_read(4'd3, 32'h10, 4'd3, 3'd2, 2'b01, -1, 0);
        for (int i = 0; i < 4; i++) chk("incr_read_lit", rd_beats[i], 32'hA0 + 32'(i));

        axi_read(4'd4, 32'h38, 4'd3, 3'd2, 2'b10, -1, 0);
        chk("wrap_b0", rd_beats[0], 32'h10E);
        chk("wrap_b1", rd_beats[1], 32'h10F);
        chk("wrap_b2", rd_beats[2], 32'h10C);
        chk("wrap_b3", rd_beats[3], 32'h10D);
        axi_read(4'd4, 32'h38, 4'd2, 3'd2, 2'b10, -1, 0);
        chk("wrap_badlen_resp", rd_resp[0], 2'b10);

        axi_write(4'd5, 32'h20, 4'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, -1, -1, 0);
        axi_write(4'd5, 32'h20, 4'd0, 3'd2, 2'b01, 32'h11223344, 4'b0101, -1, -1, 0);
        axi_read(4'd6, 32'h20, 4'd0, 3'd2, 2'b01, -1, 0);
        chk("strobe_lit", rd_beats[0], 32'hFF22FF44);

        // Backpressure on B and on R beat 1.
        axi_write(4'd7, 32'h40, 4'd3, 3'd2, 2'b01, 32'hC0, 4'hF, -1, -1, 5);
        axi_read(4'd8, 32'h40, 4'd3, 3'd2, 2'b01, 1, 5);
        chk("bp_read_b1", rd_beats[1], 32'hC1);

        // Error paths.
        axi_write(4'd9, MEMTOP, 4'd0, 3'd2, 2'b01, 32'hDEAD, 4'hF, -1, -1, 0);
        chk("oor_bresp", last_bresp, 2'b10);
        axi_read(4'd9, 32'h0, 4'd0, 3'd2, 2'b01, -1, 0);
        chk("oor_mem_untouched", rd_beats[0], 32'h100);
        axi_write(4'd10, 32'h60, 4'd3, 3'd2, 2'b01, 32'hE0, 4'hF, -1, 1, 0);
        chk("early_wlast_bresp", last_bresp, 2'b10);
        axi_read(4'd10, 32'h60, 4'd3, 3'd2, 2'b01, -1, 0);
        axi_write(4'd11, 32'h70, 4'd1, 3'd2, 2'b11, 32'hF0, 4'hF, -1, -1, 0);
        chk("burst3_bresp", last_bresp, 2'b10);
        axi_read(4'd11, 32'h70, 4'd1, 3'd2, 2'b01, -1, 0);
        axi_write(4'd12, 32'h80, 4'd1, 3'd2, 2'b01, 32'h80, 4'hF, 1, -1, 0);
        axi_write(4'd13, MEMTOP - 4, 4'd0, 3'd2, 2'b01, 32'h55, 4'hF, -1, -1, 0);
        axi_read(4'd13, MEMTOP - 4, 4'd1, 3'd2, 2'b01, -1, 0);
        chk("oor_read_b0", rd_beats[0], 32'h55);
        chk("oor_read_b1", {rd_beats[1][29:0], rd_resp[1]}, {30'd0, 2'b10});

        // Reset in the middle of an 8-beat read, after two beats.
        expect_read(4'd14, 32'h0, 4'd7, 3'd2, 2'b01);
        arid = 4'd14; araddr = 32'h0; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
        beats = 0;
        for (int t = 0; t < 50 && beats == 0; t++) begin
            @(negedge clk);
            if (arready) beats = 1;
        end
        if (beats == 0) timeout("ar_accept_rst");
        @(posedge clk); #1;
        arvalid = 0;
        rready = 1;
        beats = 0;
        for (int t = 0; t < 50 && beats < 2; t++) begin
            @(negedge clk);
            if (rvalid && rready) beats++;
            @(posedge clk); #1;
        end
        chk("rst_beats_before", beats, 2);
        rready = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_rvalid_now", {rvalid, rlast, arready}, 3'b000);
        exp_r.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_arready_low", arready, 1'b0);
        @(posedge clk); #1;
        chk("rst_arready_high", {arready, awready}, 2'b11);
        axi_read(4'd15, 32'h10, 4'd3, 3'd2, 2'b01, -1, 0);
        chk("post_rst_read", rd_beats[3], 32'hA3);
        axi_write(4'd1, 32'h90, 4'd1, 3'd2, 2'b00, 32'h77, 4'hF, -1, -1, 0);
        axi_read(4'd2, 32'h90, 4'd0, 3'd2, 2'b01, -1, 0);
        chk("fixed_last_wins", rd_beats[0], 32'h78);

        repeat (2) @(posedge clk);
        chk("r_leftover", exp_r.size(), 0);
        chk("b_leftover", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
